gsensor_spi_ctrl: RTL and testbench

GSENSOR_SPI_CTRL -- requirements
Module: gsensor_spi_ctrl

---
 rtl/gsensor_pkg.sv | 35 +++
 rtl/gsensor_sclk_gen.sv | 38 +++
 rtl/gsensor_spi_ctrl.sv | 156 +++++++++++++++
 tb/tb_gsensor_spi_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_pkg.sv
// gsensor_pkg: shared types and constants for the ADXL345 SPI controller.
// Holds the FSM encoding, header layout and device register map.
package gsensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int HDR_RW_BIT = 7;
    localparam int HDR_MB_BIT = 6;
    localparam int HDR_ADDR_W = 6;

    localparam logic [5:0] ADXL_DEVID     = 6'h00;
    localparam logic [7:0] ADXL_DEVID_VAL = 8'hE5;
    localparam logic [5:0] ADXL_POWER_CTL = 6'h2D;
    localparam logic [5:0] ADXL_DATAX0    = 6'h32;

    function automatic logic [7:0] make_header(
        input logic       rw,
        input logic       mb,
        input logic [5:0] addr
    );
        logic [7:0] h;
        h = '0;
        h[HDR_RW_BIT] = rw;
        h[HDR_MB_BIT] = mb;
        h[HDR_ADDR_W-1:0] = addr;
        return h;
    endfunction

endpackage

// File: rtl/gsensor_sclk_gen.sv
// gsensor_sclk_gen: SCLK divider for SPI mode 3.
// Idles high; toggles every CLK_DIV cycles while enabled, first edge a fall.
module gsensor_sclk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    // Half-period counter; SCLK parks high whenever the divider is off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gsensor_spi_ctrl.sv
// gsensor_spi_ctrl: SPI mode-3 master for the ADXL345 accelerometer.
// One register write or burst read per command; read bytes are strobed out.
module gsensor_spi_ctrl
    import gsensor_pkg::*;
#(
    parameter int CLK_DIV = 25,
    parameter int MAX_LEN = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic [2:0] cmd_len,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_last,
    output logic       done,
    output logic       busy,
    output logic       gsensor_SCLK,
    output logic       gsensor_MOSI,
    output logic       gsensor_SS_n,
    input  logic       gsensor_MISO
);
    localparam int PW = $clog2(CLK_DIV);

    state_t        state, state_nxt;
    logic [PW-1:0] ph_cnt;
    logic          ph_end;
    logic          accept;
    logic          sclk_en, sclk_rise, sclk_fall;
    logic          rst_done;
    logic          rw_q;
    logic [1:0]    miso_sync;
    logic          miso_s;
    logic [6:0]    bit_cnt, last_bit;
    logic [15:0]   tx_sr;
    logic [6:0]    rx_sr;
    logic [2:0]    len_eff, n_bytes;
    logic [7:0]    header;
    logic          byte_end;

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len == 3'd0) return 3'd1;
        if (int'(len) > MAX_LEN) return 3'(MAX_LEN);
        return len;
    endfunction

    assign len_eff  = clamp_len(cmd_len);
    assign n_bytes  = cmd_rw ? len_eff : 3'd1;
    assign header   = make_header(cmd_rw, cmd_rw && (len_eff > 3'd1), cmd_addr);
    assign ph_end   = (ph_cnt == PW'(CLK_DIV - 1));
    assign accept   = cmd_valid && cmd_ready;
    assign miso_s   = miso_sync[1];
    assign byte_end = rw_q && (bit_cnt >= 7'd15) && (bit_cnt[2:0] == 3'd7);

    gsensor_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (sclk_en),
        .sclk   (gsensor_SCLK),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: timed phases around the shift, shift ends on last rise.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SETUP;
            ST_SETUP: if (ph_end) state_nxt = ST_SHIFT;
            ST_SHIFT: if (sclk_rise && bit_cnt == last_bit) state_nxt = ST_HOLD;
            ST_HOLD:  if (ph_end) state_nxt = ST_GAP;
            ST_GAP:   if (ph_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Per-state outputs; ready is held off until the first clock after reset.
    always_comb begin
        cmd_ready    = (state == ST_IDLE) && rst_done;
        busy         = (state != ST_IDLE);
        gsensor_SS_n = (state == ST_IDLE) || (state == ST_GAP);
        sclk_en      = (state == ST_SHIFT);
    end

    // Phase timer for SETUP, HOLD and GAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                ph_cnt <= '0;
        else if (state_nxt != state) ph_cnt <= '0;
        else if (state == ST_SETUP || state == ST_HOLD || state == ST_GAP)
            ph_cnt <= ph_cnt + 1'b1;
        else                         ph_cnt <= '0;
    end

    // Two-flop MISO synchronizer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) miso_sync <= '0;
        else          miso_sync <= {miso_sync[0], gsensor_MISO};
    end

    // Shift datapath: latch command, drive MOSI on falls, sample on rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_done     <= 1'b0;
            rw_q         <= 1'b0;
            last_bit     <= '0;
            bit_cnt      <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            gsensor_MOSI <= 1'b0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            rd_data      <= '0;
            done         <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
            if (accept) begin
                rw_q         <= cmd_rw;
                last_bit     <= {1'b0, n_bytes, 3'b111};
                bit_cnt      <= '0;
                tx_sr        <= {header, cmd_rw ? 8'h00 : cmd_wdata};
                gsensor_MOSI <= header[HDR_RW_BIT];
            end
            if (sclk_fall) gsensor_MOSI <= tx_sr[15];
            if (sclk_rise) begin
                tx_sr   <= {tx_sr[14:0], 1'b0};
                rx_sr   <= {rx_sr[5:0], miso_s};
                bit_cnt <= bit_cnt + 1'b1;
                if (byte_end) begin
                    rd_valid <= 1'b1;
                    rd_data  <= {rx_sr, miso_s};
                    rd_last  <= (bit_cnt == last_bit);
                end
            end
            if (state == ST_HOLD && ph_end) begin
                done         <= 1'b1;
                gsensor_MOSI <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gsensor_spi_ctrl.sv
// tb_gsensor_spi_ctrl: directed and random transactions against a mode-3
// ADXL345-style slave model, with per-transaction expectations.
module tb_gsensor_spi_ctrl;
    import gsensor_pkg::*;

    localparam int D  = 4;
    localparam int ML = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [5:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic [2:0] cmd_len = '0;
    logic       cmd_ready, rd_valid, rd_last, done, busy;
    logic [7:0] rd_data;
    logic       sclk, mosi, ss_n;
    logic       miso = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gsensor_spi_ctrl #(
        .CLK_DIV(D),
        .MAX_LEN(ML)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_len     (cmd_len),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .done        (done),
        .busy        (busy),
        .gsensor_SCLK(sclk),
        .gsensor_MOSI(mosi),
        .gsensor_SS_n(ss_n),
        .gsensor_MISO(miso)
    );

    // Slave model: mode 3, header then data bytes from slave_mem.
    logic [7:0]  slave_mem [8];
    int          rises = 0;
    int          falls = 0;
    int          late_ones = 0;
    logic [15:0] mosi_sr = '0;

    logic [7:0] hdr_q[$];
    logic [7:0] b2_q[$];
    int         rise_q[$];
    int         late_q[$];
    logic [7:0] rd_q[$];
    logic       last_q[$];
    int         gap_q[$];
    int         done_cnt = 0;
    int         hi_run = 0;

    always @(negedge ss_n) begin
        rises = 0;
        falls = 0;
        late_ones = 0;
        mosi_sr = '0;
        miso = 1'b0;
    end

    always @(posedge sclk) begin
        if (ss_n === 1'b0) begin
            rises++;
            if (rises <= 16) mosi_sr = {mosi_sr[14:0], mosi};
            else if (mosi !== 1'b0) late_ones++;
        end
    end

    always @(negedge sclk) begin
        int k;
        if (ss_n === 1'b0) begin
            falls++;
            if (falls > 8) begin
                k = falls - 9;
                miso = slave_mem[(k / 8) % 8][7 - (k % 8)];
            end
        end
    end

    always @(posedge ss_n) begin
        hdr_q.push_back(mosi_sr[15:8]);
        b2_q.push_back(mosi_sr[7:0]);
        rise_q.push_back(rises);
        late_q.push_back(late_ones);
    end

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            rd_q.push_back(rd_data);
            last_q.push_back(rd_last);
        end
        if (done === 1'b1) done_cnt++;
        if (ss_n === 1'b1) hi_run++;
        else begin
            if (hi_run > 0) gap_q.push_back(hi_run);
            hi_run = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        hdr_q.delete();
        b2_q.delete();
        rise_q.delete();
        late_q.delete();
        rd_q.delete();
        last_q.delete();
        gap_q.delete();
        done_cnt = 0;
        hi_run = 0;
    endtask

    task automatic issue(input logic rw, input logic [5:0] a,
                         input logic [7:0] wd, input logic [2:0] len,
                         output int cycles);
        int w;
        w = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        cmd_rw = rw;
        cmd_addr = a;
        cmd_wdata = wd;
        cmd_len = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cycles = 0;
        @(negedge clk);
        while (busy === 1'b1 && cycles < 5000) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // Model: expected frame derived from the command rules.
    task automatic run(input string tag, input logic rw, input logic [5:0] a,
                       input logic [7:0] wd, input logic [2:0] len);
        int le, n, cyc, exp_hdr;
        le = (len == 0) ? 1 : ((int'(len) > ML) ? ML : int'(len));
        n = rw ? le : 1;
        exp_hdr = (rw ? 128 : 0) + ((rw && le > 1) ? 64 : 0) + int'(a);
        clear_mon();
        issue(rw, a, wd, len, cyc);
        repeat (2) @(negedge clk);
        check({tag, "_cycles"}, cyc, 3 * D + 16 * D * (1 + n));
        check({tag, "_frames"}, hdr_q.size(), 1);
        check({tag, "_hdr"}, (hdr_q.size() > 0) ? hdr_q[0] : 8'hxx, exp_hdr);
        check({tag, "_byte2"}, (b2_q.size() > 0) ? b2_q[0] : 8'hxx,
              rw ? 8'h00 : wd);
        check({tag, "_rises"}, (rise_q.size() > 0) ? rise_q[0] : -1,
              8 * (1 + n));
        check({tag, "_mosi_idle"}, (late_q.size() > 0) ? late_q[0] : -1, 0);
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_rdcount"}, rd_q.size(), rw ? le : 0);
        for (int i = 0; i < rd_q.size() && i < 8; i++) begin
            check($sformatf("%s_rd%0d", tag, i), rd_q[i], slave_mem[i]);
            check($sformatf("%s_last%0d", tag, i), last_q[i], i == le - 1);
        end
    endtask

    initial begin
        int w;
        logic rr;
        logic [5:0] ra;
        logic [7:0] rwd;
        logic [2:0] rl;

        // Asynchronous reset before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        check("rst_ss_n", ss_n, 1'b1);
        check("rst_sclk", sclk, 1'b1);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check("rst_ready_rise", cmd_ready, 1'b1);

        // Register write: POWER_CTL <= 0x08, length field ignored.
        run("wr_pwr", 1'b0, ADXL_POWER_CTL, 8'h08, 3'd5);

        // Single-byte read of the device ID.
        slave_mem[0] = ADXL_DEVID_VAL;
        run("rd_id", 1'b1, ADXL_DEVID, 8'h00, 3'd1);

        // Six-byte burst of the data registers.
        for (int i = 0; i < 8; i++) slave_mem[i] = 8'(i + 1);
        run("rd_xyz", 1'b1, ADXL_DATAX0, 8'h00, 3'd6);

        // Over-long burst clamps to the maximum.
        for (int i = 0; i < 8; i++) slave_mem[i] = 8'($urandom);
        run("rd_clamp", 1'b1, ADXL_DATAX0, 8'h00, 3'd7);

        // Reset at the fifth header rise aborts the transfer.
        clear_mon();
        slave_mem[0] = ADXL_DEVID_VAL;
        @(negedge clk);
        cmd_rw = 1'b1;
        cmd_addr = ADXL_DEVID;
        cmd_len = 3'd1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        w = 0;
        while (!(ss_n === 1'b0 && rises >= 5) && w < 2000) begin
            @(posedge clk);
            #1 w++;
        end
        check("abort_reached", rises, 5);
        reset_n = 1'b0;
        #1;
        check("abort_ss_n", ss_n, 1'b1);
        check("abort_sclk", sclk, 1'b1);
        check("abort_busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_rd", rd_q.size(), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check("abort_ready", cmd_ready, 1'b1);
        run("post_abort", 1'b1, ADXL_DEVID, 8'h00, 3'd1);

        // Valid held through busy: second command waits for IDLE.
        clear_mon();
        slave_mem[0] = ADXL_DEVID_VAL;
        @(negedge clk);
        cmd_rw = 1'b1;
        cmd_addr = ADXL_DEVID;
        cmd_len = 3'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_addr = ADXL_DATAX0;
        w = 0;
        while (!(done_cnt == 1 && ss_n === 1'b0) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b0;
        while (busy === 1'b1 && w < 6000) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        check("b2b_frames", hdr_q.size(), 2);
        check("b2b_hdr0", (hdr_q.size() > 0) ? hdr_q[0] : 8'hxx, 8'h80);
        check("b2b_hdr1", (hdr_q.size() > 1) ? hdr_q[1] : 8'hxx, 8'hB2);
        check("b2b_rises1", (rise_q.size() > 1) ? rise_q[1] : -1, 16);
        check("b2b_done", done_cnt, 2);
        check("b2b_rdcount", rd_q.size(), 2);
        check("b2b_rd1", (rd_q.size() > 1) ? rd_q[1] : 8'hxx, 8'hE5);
        check("b2b_last1", (last_q.size() > 1) ? last_q[1] : 1'bx, 1'b1);
        check("b2b_gap_ge", (gap_q.size() > 1) ? (gap_q[1] >= D) : 1'b0, 1'b1);

        // Random commands against the model.
        for (int t = 0; t < 8; t++) begin
            rr = 1'($urandom);
            ra = 6'($urandom);
            rwd = 8'($urandom);
            rl = 3'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++) slave_mem[i] = 8'($urandom);
            run($sformatf("rnd%0d", t), rr, ra, rwd, rl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
